// File: rtl/fiber_evt_tx_framer_pkg.sv
// fiber_evt_tx_framer_pkg: shared state encoding, header tag and buffer entry layout.
package fiber_evt_tx_framer_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;
    localparam logic [7:0] HDR_TAG = 8'hE0;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = DATA_W + 1;
    localparam int END_BIT = DATA_W;
    typedef logic [ENTRY_W-1:0] entry_t;
endpackage

// File: rtl/fiber_tx_sync_fifo.sv
// fiber_tx_sync_fifo: single-clock first-word-fall-through FIFO of {end, data} entries with occupancy,
// registered almost-full and a write-while-full guard that still accepts a write paired with a pop.
module fiber_tx_sync_fifo
    import fiber_evt_tx_framer_pkg::*;
#(
    parameter int DEPTH_LOG2  = 9,
    parameter int FULL_MARGIN = 4
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic                wr,
    input  entry_t              wr_entry,
    input  logic                pop,
    output entry_t              head,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level,
    output logic                almost_full,
    output logic                dropped
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    entry_t mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, level_n;
    logic full, wr_ok, rd_ok;
    assign level   = wr_ptr - rd_ptr;
    assign empty   = level == '0;
    assign full    = level[DEPTH_LOG2];
    assign rd_ok   = pop && !empty;
    assign wr_ok   = wr && (!full || rd_ok);
    assign dropped = wr && !wr_ok;
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign level_n = level + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
    always_ff @(posedge CLK)
        if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + (DEPTH_LOG2+1)'(wr_ok);
            rd_ptr      <= rd_ptr + (DEPTH_LOG2+1)'(rd_ok);
            almost_full <= level_n >= (DEPTH_LOG2+1)'(DEPTH - FULL_MARGIN);
        end
    end
endmodule

// File: rtl/fiber_evt_tx_framer.sv
// fiber_evt_tx_framer: buffers event blocks and streams each as Aurora TX LocalLink frames.
// Define FIBER_TX_HEADER_EN to prefix every frame with a {E0, 00, seq} header beat.
module fiber_evt_tx_framer
    import fiber_evt_tx_framer_pkg::*;
#(
    parameter int DEPTH_LOG2      = 9,
    parameter int FULL_MARGIN     = 4,
    parameter int MAX_FRAME_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        ENABLE,
    input  logic        CHANNEL_UP,
    input  logic        EVT_FIFO_WR,
    input  logic [31:0] EVT_FIFO_DATA,
    input  logic        EVT_FIFO_END,
    output logic        EVT_FIFO_FULL,
    output logic [31:0] TX_D,
    output logic        TX_SRC_RDYb,
    output logic        TX_SOFb,
    output logic        TX_EOFb,
    input  logic        TX_DST_RDYb,
    output logic        OVERFLOW,
    output logic [31:0] FRAME_COUNT,
    output logic [15:0] ABORT_COUNT
);
    localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
    state_t state, state_n;
    logic [DATA_W-1:0] h, h_n, tx_word;
    logic [CW-1:0] wordcnt, cnt_n;
    logic [DEPTH_LOG2:0] level;
    entry_t head;
    logic sof_p, sof_n, pop, fin, abort, hdr_beat, empty, dropped, head_mark, last, more, xfer;

    fiber_tx_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .FULL_MARGIN(FULL_MARGIN)) u_fifo (
        .CLK(CLK), .RSTb(RSTb), .wr(EVT_FIFO_WR),
        .wr_entry({EVT_FIFO_END, EVT_FIFO_END ? 32'h0 : EVT_FIFO_DATA}),
        .pop(pop), .head(head), .empty(empty), .level(level),
        .almost_full(EVT_FIFO_FULL), .dropped(dropped)
    );

    assign head_mark = !empty && head[END_BIT];
    assign more      = level > (DEPTH_LOG2+1)'(1);
    assign last      = wordcnt == CW'(MAX_FRAME_WORDS);
    assign xfer      = !TX_DST_RDYb;

`ifdef FIBER_TX_HEADER_EN
    logic [15:0] seq;
    assign hdr_beat = sof_p;
    assign tx_word  = hdr_beat ? {HDR_TAG, 8'h00, seq} : h;
    always_ff @(posedge CLK or negedge RSTb)
        if (!RSTb) seq <= '0;
        else if (state == STREAM && CHANNEL_UP && xfer && hdr_beat) seq <= seq + 16'd1;
`else
    assign hdr_beat = 1'b0;
    assign tx_word  = h;
`endif

    // STREAM is only entered with the entry after H already visible, so head_mark is stable while stalled
    assign TX_SRC_RDYb = state != STREAM;
    assign TX_SOFb     = !(state == STREAM && sof_p);
    assign TX_EOFb     = !(state == STREAM && !hdr_beat && (head_mark || last));
    assign TX_D        = tx_word;

    always_comb begin
        state_n = state;
        h_n     = h;
        sof_n   = sof_p;
        cnt_n   = wordcnt;
        pop     = 1'b0;
        fin     = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE:
                if (head_mark) pop = 1'b1;
                else if (!empty && ENABLE && CHANNEL_UP) begin
                    pop     = 1'b1;
                    h_n     = head[DATA_W-1:0];
                    sof_n   = 1'b1;
                    cnt_n   = CW'(1);
                    state_n = more ? STREAM : LOAD;
                end
            LOAD:
                if (!CHANNEL_UP) begin
                    abort   = 1'b1;
                    state_n = FLUSH;
                end else if (!empty) state_n = STREAM;
            STREAM:
                if (!CHANNEL_UP) begin
                    abort   = 1'b1;
                    state_n = FLUSH;
                end else if (xfer) begin
                    if (hdr_beat) sof_n = 1'b0;
                    else if (head_mark) begin
                        pop     = 1'b1;
                        fin     = 1'b1;
                        state_n = IDLE;
                    end else begin
                        pop     = 1'b1;
                        fin     = last;
                        h_n     = head[DATA_W-1:0];
                        sof_n   = last;
                        cnt_n   = last ? CW'(1) : wordcnt + CW'(1);
                        state_n = more ? STREAM : LOAD;
                    end
                end
            FLUSH:
                if (!empty) begin
                    pop = 1'b1;
                    if (head[END_BIT]) state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state       <= IDLE;
            h           <= '0;
            sof_p       <= 1'b0;
            wordcnt     <= '0;
            OVERFLOW    <= 1'b0;
            FRAME_COUNT <= '0;
            ABORT_COUNT <= '0;
        end else begin
            state       <= state_n;
            h           <= abort ? '0 : h_n;
            sof_p       <= sof_n;
            wordcnt     <= cnt_n;
            OVERFLOW    <= OVERFLOW | dropped;
            FRAME_COUNT <= FRAME_COUNT + 32'(fin);
            if (abort && ABORT_COUNT != 16'hFFFF) ABORT_COUNT <= ABORT_COUNT + 16'd1;
        end
    end
endmodule

// File: doc/fiber_evt_tx_framer.md
# fiber_evt_tx_framer

Buffers event words written by the fiber event handler and streams them to the Aurora TX LocalLink port, one LocalLink frame per event block. Each block is terminated by an end marker, which becomes the EOF of the frame. The block sits between the event handler's EVT_FIFO_WR/DATA/END/FULL outputs and the Aurora core TX user interface, inside the fiber clock domain.

## Interface
- DEPTH_LOG2, 9: buffer depth is 2**DEPTH_LOG2 entries, each 33 bits ({end, data}).
- FULL_MARGIN, 4: EVT_FIFO_FULL asserts when free entries are at or below this value.
- MAX_FRAME_WORDS, 256: longest LocalLink frame. Longer blocks are split across several frames.
- CLK  in  1  system clock.
- RSTb  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  permits new frames to start.
- CHANNEL_UP  in  1  Aurora channel up.
- EVT_FIFO_WR  in  1  write strobe.
- EVT_FIFO_DATA  in  32  event word.
- EVT_FIFO_END  in  1  with WR: end marker. DATA is ignored for a marker write.
- EVT_FIFO_FULL  out  1  registered almost-full flag.
- TX_D  out  32  LocalLink data.
- TX_SRC_RDYb  out  1  data valid, active-low.
- TX_SOFb, TX_EOFb  out  1  frame delimiters, active-low.
- TX_DST_RDYb  in  1  Aurora ready, active-low.
- OVERFLOW  out  1  sticky: a write arrived while the buffer was truly full. Cleared only by reset.
- FRAME_COUNT  out  32  frames completed (EOF beats transferred). Wraps.
- ABORT_COUNT  out  16  blocks aborted by channel-down. Saturates at 0xFFFF.

## Operation
- Write side:
  - A write is accepted when the buffer is not truly full; the entry stored is {END, END ? 0 : DATA}.
  - A write to a truly full buffer is dropped and sets OVERFLOW.
- Read side uses a hold register H (one data word) plus a one-entry peek at the buffer head.
- A beat is transferred when TX_SRC_RDYb = 0 and TX_DST_RDYb = 0 in the same cycle.
- States:
  - IDLE: all TX strobes high. If ENABLE, CHANNEL_UP and the head is a data entry: pop it into H, set SOF-pending, wordcnt = 1, go to LOAD. If the head is a marker (empty block): pop and discard, stay in IDLE.
  - LOAD: wait until the buffer is non-empty, so the entry after H is visible. Then go to STREAM.
  - STREAM: present H with TX_SRC_RDYb = 0. TX_SOFb = 0 if SOF-pending. TX_EOFb = 0 if the head is a marker or wordcnt = MAX_FRAME_WORDS.
    - On transfer with the head a marker: pop the marker, FRAME_COUNT+1, go to IDLE.
    - On transfer with wordcnt = MAX: FRAME_COUNT+1, pop the next data entry into H, set SOF-pending, wordcnt = 1, go to LOAD.
    - On any other transfer: pop the head into H, clear SOF-pending, wordcnt+1, go to LOAD.
  - FLUSH: pop and discard entries up to and including the next marker, then go to IDLE. While flushing, the buffer never asserts TX_SRC_RDYb.
- CHANNEL_UP low in LOAD or STREAM: drop H, ABORT_COUNT+1, go to FLUSH. The partial frame is never closed; Aurora discards it.
- ENABLE low mid-frame: the current frame completes normally. Only IDLE checks ENABLE.
- While TX_SRC_RDYb is low, TX_D, TX_SOFb and TX_EOFb hold stable until the transfer.

## Timing
- Reset values: EVT_FIFO_FULL = 0, TX_SRC_RDYb = TX_SOFb = TX_EOFb = 1, TX_D = 0, OVERFLOW = 0, both counters 0, state IDLE, buffer empty.
- Write-to-read latency through the buffer: 1 cycle (entry visible the cycle after the write).
- First beat of a frame appears no earlier than 3 cycles after its first data write, and only once the second entry has been written.
- Throughput: 1 beat per cycle while the buffer stays non-empty. Registered outputs; the LOAD state is skipped whenever the head is already valid.
- EVT_FIFO_FULL is updated each cycle from the occupancy after that cycle's write and pop.
- Simultaneous write and pop on a truly full buffer: the write is accepted.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally.

## Configuration
- FIBER_TX_HEADER_EN defined: each frame, including each split continuation frame, starts with an extra SOF beat {8'hE0, 8'h00, seq[15:0]}. seq increments per frame and resets to 0. Data words follow without SOF. MAX_FRAME_WORDS counts data words only.
- Undefined: no header. The first data word carries SOF.

## Structure
- Shared package: state encoding (IDLE, LOAD, STREAM, FLUSH), header tag 8'hE0, 33-bit entry layout constants.
- One sub-module: fiber_tx_sync_fifo, a single-clock 33-bit FIFO with occupancy output, first-word-fall-through, write-while-full guard.

## Test plan
- Write D0..D3 + marker, TX_DST_RDYb = 0 → 4 beats: D0 with SOF, D3 with EOF; FRAME_COUNT = 1.
- Write a 600-word block + marker, MAX = 256 → frames of 256/256/88 words, each with SOF and EOF; FRAME_COUNT = 3.
- TX_DST_RDYb toggled pseudo-randomly over 3 blocks → data and delimiters unchanged while stalled; no loss or duplication.
- Drop CHANNEL_UP after 10 beats of a 50-word block, then raise it → rest of the block discarded; ABORT_COUNT = 1; the next block transfers intact.
- Fill with DEPTH_LOG2 = 4, TX_DST_RDYb = 1 → FULL asserts at 12 entries; the 17th write sets OVERFLOW.
- Marker-only write → no TX activity; FRAME_COUNT unchanged. With FIBER_TX_HEADER_EN, a one-word block → header beat E000_0000 (SOF), then the data beat (EOF).
